// File: rtl/psubsb_seq_if.sv
// Operand/result handshake bundle for the sequential lane-wise saturating subtractor.
interface psubsb_seq_if #(
  parameter int LANE_W    = 4,
  parameter int NUM_LANES = 4
);
  localparam int DW = LANE_W * NUM_LANES;

  logic                 in_valid;
  logic                 in_ready;
  logic [DW-1:0]        a;
  logic [DW-1:0]        b;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        diff;
  logic [NUM_LANES-1:0] lane_sat;
  logic                 error;
  logic                 busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, lane_sat, error, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, lane_sat, error, busy
  );
endinterface

// File: rtl/psubsb_seq.sv
// Lane-wise signed saturating subtract, one lane per cycle through a shared
// LANE_W-bit datapath; IDLE -> CALC (NUM_LANES cycles) -> DONE (held until taken).
module psubsb_lane #(
  parameter int LANE_W = 4
) (
  input  logic [LANE_W-1:0] a_l,
  input  logic [LANE_W-1:0] b_l,
  output logic [LANE_W-1:0] res,
  output logic              ovf
);
  logic [LANE_W:0]   d;
  logic [LANE_W-1:0] sat_val;

  always_comb begin
    d       = {a_l[LANE_W-1], a_l} - {b_l[LANE_W-1], b_l};
    // Operands of differing sign whose result sign flips away from a_l overflowed.
    ovf     = (a_l[LANE_W-1] != b_l[LANE_W-1]) && (d[LANE_W-1] != a_l[LANE_W-1]);
    sat_val = a_l[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
    res     = ovf ? sat_val : d[LANE_W-1:0];
  end
endmodule

module psubsb_seq #(
  parameter int LANE_W    = 4,
  parameter int NUM_LANES = 4
) (
  input  logic        clk,
  input  logic        rst,
  psubsb_seq_if.slave io
);
  localparam int DW    = LANE_W * NUM_LANES;
  localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [DW-1:0]        a_q, b_q, diff_q;
  logic [NUM_LANES-1:0] lane_sat_q;
  logic                 in_ready_q, out_valid_q, busy_q;

  logic [LANE_W-1:0]    a_l, b_l, lane_res;
  logic                 lane_ovf;

  assign a_l = a_q[idx*LANE_W +: LANE_W];
  assign b_l = b_q[idx*LANE_W +: LANE_W];

  psubsb_lane #(.LANE_W(LANE_W)) u_lane (
    .a_l (a_l),
    .b_l (b_l),
    .res (lane_res),
    .ovf (lane_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      lane_sat_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.in_valid) begin
          a_q        <= io.a;
          b_q        <= io.b;
          diff_q     <= '0;
          lane_sat_q <= '0;
          idx        <= '0;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          state      <= CALC;
        end
        CALC: begin
          diff_q[idx*LANE_W +: LANE_W] <= lane_res;
          lane_sat_q[idx]              <= lane_ovf;
          if (idx == IDX_W'(NUM_LANES-1)) begin
            idx         <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: if (io.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.busy      = busy_q;
  assign io.diff      = diff_q;
  assign io.lane_sat  = lane_sat_q;
  assign io.error     = |lane_sat_q;
endmodule

// File: tb/tb_psubsb_seq.sv
// Scoreboard bench for psubsb_seq: directed cases, backpressure, reset abort, random back-to-back.
module tb_psubsb_seq;
  localparam int W  = 4;
  localparam int NL = 4;
  localparam int DW = W * NL;

  logic clk, rst;
  int   cyc;
  int   n_chk, n_pass;

  psubsb_seq_if #(.LANE_W(W), .NUM_LANES(NL)) io ();
  psubsb_seq #(.LANE_W(W), .NUM_LANES(NL)) dut (.clk(clk), .rst(rst), .io(io));

  typedef struct {
    logic [DW-1:0] d;
    logic [NL-1:0] s;
    int            acc;
  } exp_t;
  exp_t q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: signed integer subtract clamped to the lane range.
  function automatic void model(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                                output logic [DW-1:0] d, output logic [NL-1:0] s);
    int x, y, r;
    d = '0;
    s = '0;
    for (int i = 0; i < NL; i++) begin
      x = int'(av[i*W +: W]);
      y = int'(bv[i*W +: W]);
      if (x >= 2**(W-1)) x -= 2**W;
      if (y >= 2**(W-1)) y -= 2**W;
      r = x - y;
      if (r > 2**(W-1) - 1) begin r = 2**(W-1) - 1; s[i] = 1'b1; end
      if (r < -(2**(W-1)))  begin r = -(2**(W-1));  s[i] = 1'b1; end
      d[i*W +: W] = r[W-1:0];
    end
  endfunction

  // Output monitor: latency on out_valid rise, value check on transfer, release afterwards.
  logic ov_prev = 1'b0;
  bit   after   = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (io.out_valid && !ov_prev) begin
        if (q.size() == 0) chk("unexpected_out_valid", 32'(io.out_valid), 32'd0);
        else               chk("latency", 32'(cyc - q[0].acc), 32'd5);
      end
      if (after) begin
        chk("out_valid_drop", 32'(io.out_valid), 32'd0);
        chk("in_ready_back", 32'(io.in_ready), 32'd1);
      end
      after = 1'b0;
      if (io.out_valid && io.out_ready) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("diff", 32'(io.diff), 32'(e.d));
          chk("lane_sat", 32'(io.lane_sat), 32'(e.s));
          chk("error", 32'(io.error), 32'(|e.s));
        end
        after = 1'b1;
      end
    end
    ov_prev = io.out_valid;
  end

  task automatic do_op(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                       input logic [DW-1:0] ed, input logic [NL-1:0] es, output int acc);
    int t = 0;
    exp_t e;
    @(posedge clk); #1;
    io.in_valid = 1'b1; io.a = av; io.b = bv;
    @(negedge clk);
    while (!io.in_ready && t < 50) begin @(negedge clk); t++; end
    acc = cyc;
    if (!io.in_ready) chk("accept_timeout", 32'd0, 32'd1);
    else begin
      e.d = ed; e.s = es; e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    io.a = DW'($urandom);
    io.b = DW'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while ((q.size() != 0 || !io.in_ready) && t < 100) begin @(negedge clk); t++; end
    if (q.size() != 0 || !io.in_ready) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] ra, rb, ed, hd;
    logic [NL-1:0] es, hs;
    int            acc, prev;
    n_chk = 0; n_pass = 0; cyc = 0;
    rst = 1'b1;
    io.in_valid = 1'b0; io.a = '0; io.b = '0; io.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_diff", 32'(io.diff), 32'd0);
    chk("rst_sat", 32'(io.lane_sat), 32'd0);
    chk("rst_error", 32'(io.error), 32'd0);
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_busy", 32'(io.busy), 32'd0);
    chk("rst_in_ready", 32'(io.in_ready), 32'd1);

    // directed cases
    do_op(16'h1234, 16'h1111, 16'h0123, 4'b0000, acc);
    @(negedge clk);
    chk("busy_in_calc", 32'(io.busy), 32'd1);
    chk("in_ready_in_calc", 32'(io.in_ready), 32'd0);
    wait_idle();
    do_op(16'h7810, 16'hF121, 16'h78FF, 4'b1100, acc);
    wait_idle();
    do_op(16'h8000, 16'h8000, 16'h0000, 4'b0000, acc);
    wait_idle();
    do_op(16'h0000, 16'h8000, 16'h7000, 4'b1000, acc);
    wait_idle();

    // backpressure: hold DONE, wiggle inputs, nothing may be taken
    io.out_ready = 1'b0;
    model(16'h5A3C, 16'h1C7F, ed, es);
    do_op(16'h5A3C, 16'h1C7F, ed, es, acc);
    begin
      int t = 0;
      while (!io.out_valid && t < 20) begin @(negedge clk); t++; end
      chk("bp_out_valid_seen", 32'(io.out_valid), 32'd1);
    end
    hd = io.diff; hs = io.lane_sat;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      io.in_valid = ~io.in_valid;
      io.a = DW'($urandom); io.b = DW'($urandom);
      @(negedge clk);
      chk("bp_diff_hold", 32'(io.diff), 32'(hd));
      chk("bp_sat_hold", 32'(io.lane_sat), 32'(hs));
      chk("bp_out_valid", 32'(io.out_valid), 32'd1);
      chk("bp_in_ready", 32'(io.in_ready), 32'd0);
    end
    @(posedge clk); #1;
    io.in_valid = 1'b0; io.out_ready = 1'b1;
    wait_idle();
    do_op(16'h1234, 16'h1111, 16'h0123, 4'b0000, acc);
    wait_idle();

    // reset while processing lane 2; the aborted op is never queued
    @(posedge clk); #1;
    io.in_valid = 1'b1; io.a = 16'h7810; io.b = 16'hF121;
    @(negedge clk);
    chk("rst_test_ready", 32'(io.in_ready), 32'd1);
    @(posedge clk); #1 io.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(io.busy), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_diff", 32'(io.diff), 32'd0);
    chk("abort_sat", 32'(io.lane_sat), 32'd0);
    chk("abort_error", 32'(io.error), 32'd0);
    chk("abort_out_valid", 32'(io.out_valid), 32'd0);
    chk("abort_busy_clr", 32'(io.busy), 32'd0);
    chk("abort_in_ready", 32'(io.in_ready), 32'd1);
    repeat (7) begin
      @(negedge clk);
      chk("abort_no_out", 32'(io.out_valid), 32'd0);
    end
    do_op(16'h1234, 16'h1111, 16'h0123, 4'b0000, acc);
    wait_idle();

    // random back-to-back with out_ready tied high
    prev = 0;
    for (int k = 0; k < 20; k++) begin
      ra = DW'($urandom); rb = DW'($urandom);
      model(ra, rb, ed, es);
      do_op(ra, rb, ed, es, acc);
      if (k > 0) chk("b2b_gap", 32'(acc - prev), 32'd6);
      prev = acc;
    end
    wait_idle();
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/psubsb_seq.md
Name: psubsb_seq

Overview:
- Multi-cycle, lane-wise saturating subtractor for the ALU: diff = a - b per signed lane.
- The data word is split into NUM_LANES lanes of LANE_W bits each.
- Processes one lane per cycle through a single LANE_W-bit subtract/saturate datapath.
- Uses a valid/ready handshake on both input and output, so the ALU sequencer can issue it and backpressure the result.
- Reports per-lane saturation flags and an OR-reduced error flag.

Parameters:
- LANE_W, 4, width of one signed lane in bits (>=2).
- NUM_LANES, 4, number of lanes; data width DW = LANE_W*NUM_LANES (16 by default).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, operands a/b are valid.
- in_ready, output, 1, block can accept operands.
- a, input, DW, minuend; lane i = a[i*LANE_W +: LANE_W], two's complement.
- b, input, DW, subtrahend; same lane layout as a.
- out_valid, output, 1, diff/lane_sat/error are valid.
- out_ready, input, 1, consumer takes the result.
- diff, output, DW, saturated lane-wise difference.
- lane_sat, output, NUM_LANES, bit i = 1 when lane i saturated.
- error, output, 1, OR of lane_sat.
- busy, output, 1, high while in CALC.

Behaviour:
- Reset (synchronous, any state): state=IDLE, lane counter=0, operand regs=0.
  - Output values after reset: diff=0, lane_sat=0, error=0, out_valid=0, busy=0, in_ready=1.
- FSM states IDLE, CALC, DONE.
  - IDLE: in_ready=1. On in_valid=1, latch a and b into internal regs, clear diff/lane_sat, set lane counter=0, go to CALC. Otherwise stay.
  - CALC: in_ready=0, busy=1. Each cycle compute lane idx of the latched operands:
    - d = a_l - b_l, computed in LANE_W+1 bits.
    - Overflow when sign(a_l) != sign(b_l) and sign(d[LANE_W-1:0]) != sign(a_l).
    - On overflow, write the saturated value: 0111..1 (max positive) if a_l is non-negative, 1000..0 (min negative) if a_l is negative, and set lane_sat[idx]=1.
    - Otherwise write d[LANE_W-1:0] into diff lane idx.
    - Increment idx. After writing lane NUM_LANES-1, go to DONE; the counter returns to 0 and does not wrap past NUM_LANES-1.
  - DONE: out_valid=1; diff, lane_sat and error are held stable. When out_ready=1, go to IDLE; out_valid drops next cycle.
- Latency:
  - Accept edge at cycle 0; CALC occupies cycles 1..NUM_LANES.
  - out_valid goes high in cycle NUM_LANES+1 (cycle 5 for defaults).
  - Minimum issue interval is NUM_LANES+2 cycles.
- Saturation is always to the signed min/max of the lane. Lanes never carry into each other.
- a and b are sampled only on the accept edge; later changes on the inputs do not affect the in-flight operation.
- in_valid while not in IDLE is ignored; the operation is not queued.
- While in DONE with out_ready=0, outputs hold indefinitely.
- diff, lane_sat and error are registered outputs. They are undefined-free: they read 0 until the first result, and partially built values are visible in CALC.
  - Consumers must qualify these outputs with out_valid.
- error is combinational OR of registered lane_sat.
- Reset asserted during CALC or DONE aborts the operation. The next cycle shows reset values and in_ready=1, and no out_valid is produced for the aborted op.
- Reset has priority over in_valid and out_ready in the same cycle.

Test Plan:
1. Basic subtract:
   - Stimulus: a=0x1234, b=0x1111, out_ready=1.
   - Required: diff=0x0123, lane_sat=0000, error=0; out_valid high exactly 5 cycles after the accept edge, for 1 cycle; in_ready high again the cycle after.
2. Positive and negative saturation:
   - Stimulus: a=0x7810, b=0xF121.
   - Required: lane3 7-(-1) gives 0x7 (sat); lane2 -8-1 gives 0x8 (sat); lane1 1-2 gives 0xF; lane0 0-1 gives 0xF. Result diff=0x78FF, lane_sat=1100, error=1.
3. Boundary values:
   - Stimulus: a=0x8000, b=0x8000.
   - Required: diff=0x0000, lane_sat=0000.
   - Stimulus: a=0x0000, b=0x8000.
   - Required: diff=0x7000, lane_sat=1000.
4. Backpressure:
   - Stimulus: hold out_ready=0 for 3 cycles in DONE; toggle in_valid and change a/b during that time.
   - Required: diff, lane_sat and out_valid stable; in_ready=0; nothing accepted. After out_ready=1, the next operation uses only operands presented once in_ready=1.
5. Reset mid-operation:
   - Stimulus: assert rst for 1 cycle while in CALC at lane 2 of a=0x7810/b=0xF121.
   - Required: next cycle all outputs 0, in_ready=1, and no out_valid for the aborted op. A following a=0x1234, b=0x1111 returns 0x0123.
6. Back-to-back operations with out_ready tied high:
   - Stimulus: 20 random operand pairs.
   - Required: each result matches a per-lane saturating-subtract reference model. Accepts are spaced exactly 6 cycles apart.
